// File: rtl/dc_offset_ramp_if.sv
// Interface bundling the stream, bias-control and status signals of dc_offset_ramp.
// Latency: none (wiring only).
// Backpressure: none; the stream is strobe-qualified by ena and cannot be stalled.
// master : drives ena, data_in, offset_target, offset_load, ramp_step; observes outputs.
// slave  : the dc_offset_ramp side; drives data_out, offset_cur, ramp_busy, sat_flag.
interface dc_offset_ramp_if #(
    parameter int WIDTH      = 32,
    parameter int STEP_WIDTH = 16
);
    logic                  ena;
    logic [WIDTH-1:0]      data_in;
    logic [WIDTH-1:0]      offset_target;
    logic                  offset_load;
    logic [STEP_WIDTH-1:0] ramp_step;
    logic [WIDTH-1:0]      data_out;
    logic [WIDTH-1:0]      offset_cur;
    logic                  ramp_busy;
    logic                  sat_flag;

    modport master (
        output ena, data_in, offset_target, offset_load, ramp_step,
        input  data_out, offset_cur, ramp_busy, sat_flag
    );

    modport slave (
        input  ena, data_in, offset_target, offset_load, ramp_step,
        output data_out, offset_cur, ramp_busy, sat_flag
    );
endinterface

// File: rtl/dc_offset_ramp.sv
// Re-inserts a programmable DC bias into a signed sample stream, ramping bias changes per strobe.
// Latency: data_out is registered 1 clk after the ena cycle; holds between strobes.
// Backpressure: none; every ena strobe is consumed. Optional clamp via macro DC_OFFSET_SAT_EN.
// Ports: clk/rst (sync, active-high) plain; all other signals via dc_offset_ramp_if.slave:
//   ena strobe, data_in sample, offset_target/offset_load bias retarget, ramp_step rate,
//   data_out biased sample, offset_cur applied bias, ramp_busy, sat_flag (sticky).
// DC_OFFSET_SAT_EN undefined: sum wraps and sat_flag is tied low.
module dc_offset_ramp #(
    parameter int                      WIDTH          = 32,
    parameter int                      STEP_WIDTH     = 16,
    parameter logic signed [WIDTH-1:0] DEFAULT_OFFSET = '0
) (
    input  logic            clk,
    input  logic            rst,
    dc_offset_ramp_if.slave bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (DEFAULT_OFFSET != '0) ? ST_RAMP : ST_IDLE;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] target_q,   target_d;
    logic [WIDTH-1:0] cur_q,      cur_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             busy_q,     busy_d;

    // Ramp arithmetic: distance to target at WIDTH+1 bits so it can never overflow.
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   abs_diff;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH-1:0] step_w;

    assign diff     = {target_q[WIDTH-1], target_q} - {cur_q[WIDTH-1], cur_q};
    assign abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
    assign step_ext = {{(WIDTH+1-STEP_WIDTH){1'b0}}, bus.ramp_step};
    assign step_w   = {{(WIDTH-STEP_WIDTH){1'b0}}, bus.ramp_step};

    always_comb begin
        cur_d    = cur_q;
        target_d = target_q;
        state_d  = state_q;

        // Step toward the target held before this edge; a same-cycle load only
        // takes effect on the following strobe.
        if (bus.ena && (state_q == ST_RAMP)) begin
            if ((bus.ramp_step == '0) || (abs_diff <= step_ext)) begin
                cur_d   = target_q;
                state_d = ST_IDLE;
            end else if (diff[WIDTH]) begin
                cur_d   = cur_q - step_w;
                state_d = ST_RAMP;
            end else begin
                cur_d   = cur_q + step_w;
                state_d = ST_RAMP;
            end
        end

        // Retarget compares against the bias that will be applied after this edge,
        // so a mid-ramp reversal needs no extra cycle.
        if (bus.offset_load) begin
            target_d = bus.offset_target;
            state_d  = (bus.offset_target != cur_d) ? ST_RAMP : ST_IDLE;
        end

        busy_d = (state_d == ST_RAMP);
    end

`ifdef DC_OFFSET_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum_wide;
    logic           sum_ovf;
    logic           sat_q, sat_d;

    assign sum_wide = {bus.data_in[WIDTH-1], bus.data_in} + {cur_q[WIDTH-1], cur_q};
    // Out of range when the extra sign bit disagrees with the WIDTH-bit sign.
    assign sum_ovf  = sum_wide[WIDTH] ^ sum_wide[WIDTH-1];

    always_comb begin
        data_out_d = data_out_q;
        sat_d      = sat_q;
        if (bus.ena) begin
            if (sum_ovf) begin
                data_out_d = sum_wide[WIDTH] ? MIN_NEG : MAX_POS;
                sat_d      = 1'b1;
            end else begin
                data_out_d = sum_wide[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    // Wrapping add: the WIDTH-bit sum is the low bits of the full-precision sum.
    always_comb begin
        data_out_d = data_out_q;
        if (bus.ena) begin
            data_out_d = bus.data_in + cur_q;
        end
    end

    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            target_q   <= DEFAULT_OFFSET;
            cur_q      <= '0;
            data_out_q <= '0;
            busy_q     <= (RESET_STATE == ST_RAMP);
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            cur_q      <= cur_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.offset_cur = cur_q;
    assign bus.ramp_busy  = busy_q;

endmodule

// File: tb/tb_dc_offset_ramp.sv
// Scoreboard bench for dc_offset_ramp at WIDTH=16, STEP_WIDTH=15, DEFAULT_OFFSET=1000.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// Saturation expectations follow DC_OFFSET_SAT_EN.
module tb_dc_offset_ramp;

    localparam int W = 16;
    localparam int SW = 15;

`ifdef DC_OFFSET_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] cur;
        logic         busy;
        logic         sat;
    } exp_t;

    logic clk;
    logic rst;

    dc_offset_ramp_if #(.WIDTH(W), .STEP_WIDTH(SW)) bus ();

    dc_offset_ramp #(
        .WIDTH          (W),
        .STEP_WIDTH     (SW),
        .DEFAULT_OFFSET (16'sd1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    // Monitor: every cycle that has a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if (bus.data_out !== e.out || bus.offset_cur !== e.cur ||
                bus.ramp_busy !== e.busy || bus.sat_flag !== e.sat) begin
                n_bad++;
                $display("FAIL %s: got out=%0d cur=%0d busy=%b sat=%b, want out=%0d cur=%0d busy=%b sat=%b",
                         nm, $signed(bus.data_out), $signed(bus.offset_cur), bus.ramp_busy, bus.sat_flag,
                         $signed(e.out), $signed(e.cur), e.busy, e.sat);
            end
        end
    end

    // Drive one cycle of inputs, then queue what must be visible after the edge.
    task automatic apply(input string nm, input logic r, input logic en, input int din,
                         input logic ld, input int tgt, input int stp,
                         input int eo, input int ec, input logic eb, input logic es);
        exp_t e;
        int   din_v, tgt_v, stp_v, eo_v, ec_v;
        din_v = din; tgt_v = tgt; stp_v = stp; eo_v = eo; ec_v = ec;
        rst               = r;
        bus.ena           = en;
        bus.data_in       = din_v[W-1:0];
        bus.offset_load   = ld;
        bus.offset_target = tgt_v[W-1:0];
        bus.ramp_step     = stp_v[SW-1:0];
        @(posedge clk);
        e.out  = eo_v[W-1:0];
        e.cur  = ec_v[W-1:0];
        e.busy = eb;
        e.sat  = es;
        exp_q.push_back(e);
        name_q.push_back(nm);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0; bus.data_in = '0; bus.offset_load = 1'b0;
        bus.offset_target = '0; bus.ramp_step = '0;
        @(posedge clk); #1;

        //     name          rst en  din    ld  tgt    stp  out     cur    busy sat
        apply("reset",       1, 1,  5,     1,  0,     300, 0,      0,     1,   0);
        apply("ramp0",       0, 1,  5,     0,  0,     300, 5,      300,   1,   0);
        apply("ramp1",       0, 1,  5,     0,  0,     300, 305,    600,   1,   0);
        apply("ramp2",       0, 1,  5,     0,  0,     300, 605,    900,   1,   0);
        apply("ramp_end",    0, 1,  5,     0,  0,     300, 905,    1000,  0,   0);
        apply("idle",        0, 1,  5,     0,  0,     300, 1005,   1000,  0,   0);
        // Jump with ramp_step=0.
        apply("jump_load",   0, 0,  5,     1, -2000,  0,   1005,   1000,  1,   0);
        apply("jump",        0, 1,  5,     0,  0,     0,   1005,  -2000,  0,   0);
        apply("jump_hold",   0, 0,  9,     0,  0,     0,   1005,  -2000,  0,   0);
        // Reach 600, then same-cycle load+ena, then retarget to 0 mid-ramp.
        apply("to600_load",  0, 0,  0,     1,  600,   0,   1005,  -2000,  1,   0);
        apply("to600",       0, 1,  0,     0,  0,     0,  -2000,   600,   0,   0);
        apply("load_ena",    0, 1,  0,     1,  1500,  300, 600,    600,   1,   0);
        apply("retarget0",   0, 0,  0,     1,  0,     300, 600,    600,   1,   0);
        apply("rev1",        0, 1,  0,     0,  0,     300, 600,    300,   1,   0);
        apply("rev2",        0, 1,  0,     0,  0,     300, 300,    0,     0,   0);
        apply("rev_idle",    0, 1,  0,     0,  0,     300, 0,      0,     0,   0);
        // ena gating during RAMP, with a retarget inside the gap.
        apply("gate_load",   0, 0,  7,     1,  900,   300, 0,      0,     1,   0);
        apply("gate_step",   0, 1,  7,     0,  0,     300, 7,      300,   1,   0);
        for (int i = 0; i < 10; i++)
            apply("gate_hold", 0, 0, 123, (i == 4), -300, 300, 7,  300,   1,   0);
        apply("gate_res1",   0, 1,  7,     0,  0,     300, 307,    0,     1,   0);
        apply("gate_res2",   0, 1,  7,     0,  0,     300, 7,     -300,   0,   0);
        // Reset mid-ramp at 600.
        apply("rr_load",     0, 0,  1,     1,  900,   300, 7,     -300,   1,   0);
        apply("rr1",         0, 1,  1,     0,  0,     300, -299,   0,     1,   0);
        apply("rr2",         0, 1,  1,     0,  0,     300, 1,      300,   1,   0);
        apply("rr3",         0, 1,  1,     0,  0,     300, 301,    600,   1,   0);
        apply("rr_reset",    1, 1,  1,     1,  50,    300, 0,      0,     1,   0);
        apply("rr_restart",  0, 1,  1,     0,  0,     300, 1,      300,   1,   0);
        // Saturation / wrap.
        apply("sat_load",    0, 0,  0,     1,  30000, 0,   1,      300,   1,   0);
        apply("sat_jump",    0, 1,  0,     0,  0,     0,   300,    30000, 0,   0);
        apply("sat_pos",     0, 1,  5000,  0,  0,     0,   SAT ? 32767 : -30536, 30000, 0, SAT);
        apply("sat_sticky",  0, 1,  0,     0,  0,     0,   30000,  30000, 0,   SAT);
        apply("neg_load",    0, 0,  0,     1, -100,   0,   30000,  30000, 1,   SAT);
        apply("neg_jump",    0, 1,  0,     0,  0,     0,   30000, -100,   0,   SAT);
        apply("sat_neg",     0, 1, -32768, 0,  0,     0,   SAT ? -32768 : 32668, -100, 0, SAT);
        apply("sat_after",   0, 1,  0,     0,  0,     0,  -100,   -100,   0,   SAT);

        bus.ena = 1'b0; bus.offset_load = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dc_offset_ramp.md
Name: dc_offset_ramp

Overview:
- Output-path counterpart to the input DC blocker. The blocker strips DC from the ADC stream; this block re-inserts a programmable DC bias into the sample stream before the sigma-delta DAC modulator.
- Typical use: centring a signed stream at DAC mid-scale.
- Bias changes are ramped at a programmable rate, once per sample strobe, to avoid audible clicks/pops. The bias ramps up from zero automatically after reset.

Parameters:
- WIDTH, 32, sample, bias and output width (two's complement).
- STEP_WIDTH, 16, width of ramp_step (unsigned); must be <= WIDTH-1.
- DEFAULT_OFFSET, 0, signed bias targeted automatically after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  sample strobe; all datapath/ramp updates occur only when ena=1
- data_in  in  WIDTH  signed input sample
- offset_target  in  WIDTH  signed new bias target, sampled on offset_load
- offset_load  in  1  single-cycle pulse; latches offset_target (independent of ena)
- ramp_step  in  STEP_WIDTH  unsigned bias change per ena; 0 = jump in one ena
- data_out  out  WIDTH  signed data_in + offset_cur, registered
- offset_cur  out  WIDTH  current applied bias
- ramp_busy  out  1  high while offset_cur != latched target
- sat_flag  out  1  sticky; set when an output sample saturated, cleared by rst only

Behaviour:
- Reset (clk edge with rst=1) sets:
  - data_out=0, offset_cur=0, sat_flag=0
  - latched target=DEFAULT_OFFSET
  - state=RAMP if DEFAULT_OFFSET!=0, else IDLE
  - ramp_busy follows the state
- rst has priority over ena and offset_load in the same cycle. Reset mid-ramp abandons the ramp and restarts from 0.
- States:
  - IDLE: offset_cur==target; ramp_busy=0.
  - RAMP: offset_cur!=target; ramp_busy=1.
- offset_load=1:
  - Target register takes offset_target on that edge, in either state.
  - Next state = RAMP if the new target != offset_cur, else IDLE.
  - Mid-ramp retarget reverses or continues direction with no extra latency.
- Ramp update (state RAMP and ena=1):
  - d = target - offset_cur, computed at WIDTH+1 bits.
  - If ramp_step==0 or |d| <= ramp_step: offset_cur<=target; state->IDLE.
  - Else: offset_cur <= offset_cur ± ramp_step (zero-extended) toward target.
  - No overshoot ever.
- offset_load and ena in the same cycle: the ramp step uses the old target; the new target applies from the next ena.
- Datapath:
  - On ena: data_out <= data_in + offset_cur, using offset_cur before this cycle's ramp update.
  - The sum is computed at WIDTH+1 bits, then reduced to WIDTH as defined under Optional Feature.
  - Latency: 1 clk after the ena cycle. data_out holds between strobes.
- ena=0: data_out, offset_cur and the state hold; only offset_load and rst act.
- ramp_busy and offset_cur are registered outputs, updated on the same edge as the state.

Optional Feature:
- Macro: DC_OFFSET_SAT_EN.
- Defined:
  - A WIDTH+1 sum exceeding the signed WIDTH range clamps to max positive (2^(WIDTH-1)-1) or min negative (-2^(WIDTH-1)).
  - sat_flag is set on the same edge the clamped value is registered.
- Undefined:
  - The sum wraps (low WIDTH bits).
  - sat_flag is tied to 0.
  - No saturation logic is synthesized.

Test Plan:
- Reset ramp, DEFAULT_OFFSET=1000, ramp_step=300, ena every cycle:
  - offset_cur goes 0 -> 300 -> 600 -> 900 -> 1000.
  - ramp_busy falls on the edge offset_cur reaches 1000.
  - data_in=5 gives data_out 5, 305, 605, 905, 1005.
- Jump: IDLE at 1000, ramp_step=0, load target -2000, then ena:
  - offset_cur=-2000 after the first ena; ramp_busy high for exactly that interval.
- Mid-ramp retarget, at offset_cur=600, ramp_step=300:
  - Load target 0 -> sequence continues 300, 0, then IDLE; no overshoot past 0.
- Saturation, WIDTH=16, DC_OFFSET_SAT_EN defined, offset_cur=30000, data_in=5000:
  - data_out=32767, sat_flag=1 and stays 1.
  - data_in=-40000 equivalent (-32768) with offset -100 -> data_out=-32768.
  - Without the macro: 30000+5000 -> data_out=-30536, sat_flag=0.
- ena gating, ena low for 10 cycles during RAMP:
  - offset_cur, data_out and ramp_busy unchanged.
  - offset_load during the gap updates the target; the ramp resumes toward the new target on the next ena.
- Reset mid-ramp at offset_cur=600:
  - Next cycle offset_cur=0, data_out=0, ramp restarts toward DEFAULT_OFFSET.
